// File: rtl/wave_synth_pkg.sv
// Shared definitions for the waveform synthesiser: FSM state encoding and
// the default sample/phase widths also used by time_block.
package wave_synth_pkg;

    localparam int DW_DEFAULT = 12;
    localparam int PW_DEFAULT = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/wave_synth_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; tc_o flags the last
// clock of the phase (count of 1, or an idle count of 0).
module phase_counter
    import wave_synth_pkg::*;
#(
    parameter int PW = PW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [PW-1:0] load_val_i,
    output logic          tc_o
);

    logic [PW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PW'(1);
        end
    end

    assign tc_o = (cnt_q <= PW'(1));

endmodule

// File: rtl/wave_synth.sv
// Square/triangle waveform generator with shadowed configuration that only
// goes live in IDLE or at the start of a new period.
module wave_synth
    import wave_synth_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int PW = PW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          EN,
    input  logic          LOAD,
    input  logic          MODE,
    input  logic [PW-1:0] PERIOD_HI,
    input  logic [PW-1:0] PERIOD_LO,
    input  logic [DW-1:0] LEVEL_HI,
    input  logic [DW-1:0] LEVEL_LO,
    input  logic [DW-1:0] STEP,
    output logic [DW-1:0] DATA_OUT,
    output logic          CYCLE_FLAG,
    output logic          BUSY,
    output logic          CFG_ERR
);

    state_t        state_q;
    logic [DW-1:0] data_q;
    logic          flag_q;
    logic          err_q;

    logic          sh_mode_q;
    logic [PW-1:0] sh_phi_q;
    logic [PW-1:0] sh_plo_q;
    logic [DW-1:0] sh_lhi_q;
    logic [DW-1:0] sh_llo_q;
    logic [DW-1:0] sh_step_q;

    logic          live_mode_q;
    logic [PW-1:0] live_plo_q;
    logic [DW-1:0] live_lhi_q;
    logic [DW-1:0] live_llo_q;
    logic [DW-1:0] live_step_q;

    logic          load_ok;
    logic          eff_mode;
    logic [PW-1:0] eff_phi;
    logic [PW-1:0] eff_plo;
    logic [DW-1:0] eff_lhi;
    logic [DW-1:0] eff_llo;
    logic [DW-1:0] eff_step;

    logic          tc;
    logic          start;
    logic          cnt_load;
    logic [PW-1:0] cnt_val;

    function automatic logic [PW-1:0] max1(input logic [PW-1:0] len);
        return (len == '0) ? PW'(1) : len;
    endfunction

    function automatic logic [DW-1:0] rise(input logic mode, input logic [DW-1:0] cur,
                                           input logic [DW-1:0] step, input logic [DW-1:0] hi);
        logic [DW:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (!mode) return hi;
        return (sum > {1'b0, hi}) ? hi : sum[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] fall(input logic mode, input logic [DW-1:0] cur,
                                           input logic [DW-1:0] step, input logic [DW-1:0] lo);
        logic signed [DW:0] diff;
        diff = $signed({1'b0, cur}) - $signed({1'b0, step});
        if (!mode) return lo;
        return (diff < $signed({1'b0, lo})) ? lo : diff[DW-1:0];
    endfunction

    // A LOAD arriving on the same edge as a period start bypasses the shadow.
    assign load_ok  = LOAD && (LEVEL_HI >= LEVEL_LO);
    assign eff_mode = load_ok ? MODE      : sh_mode_q;
    assign eff_phi  = load_ok ? PERIOD_HI : sh_phi_q;
    assign eff_plo  = load_ok ? PERIOD_LO : sh_plo_q;
    assign eff_lhi  = load_ok ? LEVEL_HI  : sh_lhi_q;
    assign eff_llo  = load_ok ? LEVEL_LO  : sh_llo_q;
    assign eff_step = load_ok ? STEP      : sh_step_q;

    always_comb begin
        start    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = max1(eff_phi);
        case (state_q)
            IDLE:    start = EN;
            HIGH: begin
                if (tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = max1(live_plo_q);
                end
            end
            LOW:     start = tc && EN;
            default: start = 1'b0;
        endcase
        if (start) begin
            cnt_load = 1'b1;
            cnt_val  = max1(eff_phi);
        end
    end

    phase_counter #(.PW(PW)) u_phase_counter (
        .clk_i      (CLK),
        .rst_i      (RSTB),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_o       (tc)
    );

    always_ff @(posedge CLK) begin
        if (RSTB) begin
            state_q     <= IDLE;
            data_q      <= '0;
            flag_q      <= 1'b0;
            err_q       <= 1'b0;
            sh_mode_q   <= 1'b0;
            sh_phi_q    <= '0;
            sh_plo_q    <= '0;
            sh_lhi_q    <= '0;
            sh_llo_q    <= '0;
            sh_step_q   <= '0;
            live_mode_q <= 1'b0;
            live_plo_q  <= '0;
            live_lhi_q  <= '0;
            live_llo_q  <= '0;
            live_step_q <= '0;
        end else begin
            if (LOAD) begin
                err_q <= !load_ok;
                if (load_ok) begin
                    sh_mode_q <= MODE;
                    sh_phi_q  <= PERIOD_HI;
                    sh_plo_q  <= PERIOD_LO;
                    sh_lhi_q  <= LEVEL_HI;
                    sh_llo_q  <= LEVEL_LO;
                    sh_step_q <= STEP;
                end
            end
            flag_q <= 1'b0;
            if (start) begin
                // New period: config goes live, first HIGH sample starts from current DATA_OUT.
                state_q     <= HIGH;
                flag_q      <= 1'b1;
                live_mode_q <= eff_mode;
                live_plo_q  <= eff_plo;
                live_lhi_q  <= eff_lhi;
                live_llo_q  <= eff_llo;
                live_step_q <= eff_step;
                data_q      <= rise(eff_mode, data_q, eff_step, eff_lhi);
            end else begin
                case (state_q)
                    HIGH: begin
                        if (tc) begin
                            state_q <= LOW;
                            data_q  <= fall(live_mode_q, data_q, live_step_q, live_llo_q);
                        end else begin
                            data_q  <= rise(live_mode_q, data_q, live_step_q, live_lhi_q);
                        end
                    end
                    LOW: begin
                        if (tc) begin
                            state_q     <= IDLE;
                            live_mode_q <= eff_mode;
                            live_plo_q  <= eff_plo;
                            live_lhi_q  <= eff_lhi;
                            live_llo_q  <= eff_llo;
                            live_step_q <= eff_step;
                            data_q      <= eff_llo;
                        end else begin
                            data_q <= fall(live_mode_q, data_q, live_step_q, live_llo_q);
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        live_mode_q <= eff_mode;
                        live_plo_q  <= eff_plo;
                        live_lhi_q  <= eff_lhi;
                        live_llo_q  <= eff_llo;
                        live_step_q <= eff_step;
                        data_q      <= eff_llo;
                    end
                endcase
            end
        end
    end

    assign DATA_OUT   = data_q;
    assign CYCLE_FLAG = flag_q;
    assign BUSY       = (state_q != IDLE);
    assign CFG_ERR    = err_q;

endmodule
